// File: rtl/correlator_frame_serializer_pkg.sv
// Shared framing constants and size formulas for the correlator counter array and its serializer.
package correlator_frame_serializer_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'h00;
  localparam logic [7:0] FILL_BYTE    = 8'h55;
  localparam int         HEADER_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  function automatic int num_correlators(input int num_inputs);
    return num_inputs * (num_inputs - 1) / 2;
  endfunction

  function automatic int payload_bits(input int resolution, input int delay_lines,
                                      input int correlators, input int num_inputs);
    return resolution * (delay_lines * correlators + num_inputs);
  endfunction

endpackage

// File: rtl/correlator_frame_serializer.sv
// Snapshots the counter vector on each integration-end strobe and streams a header+payload
// byte frame over valid/ready; a same-length 0x55 filler frame is sent when disabled.
module correlator_frame_serializer
  import correlator_frame_serializer_pkg::*;
#(
  parameter  int RESOLUTION      = 8,
  parameter  int DELAY_LINES     = 51,
  parameter  int NUM_INPUTS      = 8,
  localparam int NUM_CORRELATORS = num_correlators(NUM_INPUTS),
  localparam int PAYLOAD_BITS    = payload_bits(RESOLUTION, DELAY_LINES, NUM_CORRELATORS, NUM_INPUTS),
  localparam int PAYLOAD_BYTES   = (PAYLOAD_BITS + 7) / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    frame_strobe,
  input  logic [PAYLOAD_BITS-1:0] counts_in,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    busy,
  output logic                    frame_dropped
);

  localparam int FRAME_BYTES = HEADER_BYTES + PAYLOAD_BYTES;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam int SNAP_W      = PAYLOAD_BYTES * 8;

  localparam logic [IDX_W-1:0] HDR_LAST   = IDX_W'(HEADER_BYTES - 1);
  localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_BYTES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic              mode_q, mode_d;
  logic [7:0]        data_d;
  logic              valid_d, busy_d, drop_d;
  logic              xfer, last_xfer, accept;

  function automatic logic [7:0] header_byte(input logic [1:0] i);
    case (i)
      2'd0:    return SYNC_BYTE;
      2'd1:    return 8'(DELAY_LINES);
      2'd2:    return 8'(NUM_INPUTS);
      default: return 8'(RESOLUTION);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      mode_q        <= 1'b0;
      byte_data     <= 8'h00;
      byte_valid    <= 1'b0;
      busy          <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      mode_q        <= mode_d;
      byte_data     <= data_d;
      byte_valid    <= valid_d;
      busy          <= busy_d;
      frame_dropped <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    mode_d    = mode_q;
    data_d    = byte_data;
    valid_d   = byte_valid;
    busy_d    = busy;
    xfer      = byte_valid && byte_ready;
    last_xfer = xfer && (state_q == PAYLOAD) && (idx_q == FRAME_LAST);
    accept    = frame_strobe && ((state_q == IDLE) || last_xfer);
    drop_d    = frame_strobe && !accept;

    if (xfer) begin
      case (state_q)
        HEADER: begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == HDR_LAST) begin
            state_d = PAYLOAD;
            data_d  = mode_q ? snap_q[7:0] : FILL_BYTE;
          end else begin
            data_d  = mode_q ? header_byte(idx_q[1:0] + 2'd1) : FILL_BYTE;
          end
        end
        PAYLOAD: begin
          if (idx_q == FRAME_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            data_d  = 8'h00;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            // Payload byte k is always the low byte after k shifts, so no wide select is needed.
            idx_d  = idx_q + IDX_W'(1);
            snap_d = snap_q >> 8;
            data_d = mode_q ? snap_d[7:0] : FILL_BYTE;
          end
        end
        default: ;
      endcase
    end

    // A strobe coinciding with the final transfer starts the next frame with no idle gap.
    if (accept) begin
      state_d = HEADER;
      idx_d   = '0;
      snap_d  = SNAP_W'(counts_in);
      mode_d  = enable;
      data_d  = enable ? SYNC_BYTE : FILL_BYTE;
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_correlator_frame_serializer.sv
// Scoreboard bench: two serializer configurations driven with randomized frames.
module tb_correlator_frame_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_a, frame_strobe_a, byte_ready_a;
  logic [95:0] counts_a;
  logic [7:0]  byte_data_a;
  logic        byte_valid_a, busy_a, frame_dropped_a;
  logic        enable_b, frame_strobe_b, byte_ready_b;
  logic [35:0] counts_b;
  logic [7:0]  byte_data_b;
  logic        byte_valid_b, busy_b, frame_dropped_b;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_a = 0, drop_a = 0, xfer_b = 0, drop_b = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  correlator_frame_serializer #(.RESOLUTION(8), .DELAY_LINES(3), .NUM_INPUTS(3)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .frame_strobe(frame_strobe_a),
    .counts_in(counts_a), .byte_data(byte_data_a), .byte_valid(byte_valid_a),
    .byte_ready(byte_ready_a), .busy(busy_a), .frame_dropped(frame_dropped_a));

  correlator_frame_serializer #(.RESOLUTION(12), .DELAY_LINES(1), .NUM_INPUTS(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .frame_strobe(frame_strobe_b),
    .counts_in(counts_b), .byte_data(byte_data_b), .byte_valid(byte_valid_b),
    .byte_ready(byte_ready_b), .busy(busy_b), .frame_dropped(frame_dropped_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met", name);
  endtask

  function automatic logic [95:0] rand96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Reference frame built directly from the framing rules.
  task automatic push_frame(input int which, input bit en, input logic [95:0] c,
                            input int res, input int dl, input int ni);
    int bits, nbytes;
    logic [7:0] hdr[4];
    logic [7:0] b;
    bits   = res * (dl * (ni * (ni - 1) / 2) + ni);
    nbytes = (bits + 7) / 8;
    hdr    = '{8'h00, 8'(dl), 8'(ni), 8'(res)};
    for (int k = 0; k < 4 + nbytes; k++) begin
      if (!en) b = 8'h55;
      else if (k < 4) b = hdr[k];
      else begin
        b = 8'h00;
        for (int j = 0; j < 8; j++)
          if (8 * (k - 4) + j < bits) b[j] = c[8 * (k - 4) + j];
      end
      if (which == 0) exp_a.push_back(b); else exp_b.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_a
    static bit prev_stall = 0;
    static logic [7:0] prev_data = 8'h00;
    logic [7:0] e;
    if (reset) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("a_stall_valid", byte_valid_a, 1);
        check("a_stall_data", byte_data_a, prev_data);
      end
      if (byte_valid_a && byte_ready_a) begin
        xfer_a++;
        if (exp_a.size() == 0) fail_now("a_unexpected_byte");
        else begin e = exp_a.pop_front(); check("a_byte", byte_data_a, e); end
      end
      if (frame_dropped_a) drop_a++;
      prev_stall = byte_valid_a && !byte_ready_a;
      prev_data  = byte_data_a;
    end
  end

  always @(negedge clk) begin : mon_b
    logic [7:0] e;
    if (!reset) begin
      if (byte_valid_b && byte_ready_b) begin
        xfer_b++;
        if (exp_b.size() == 0) fail_now("b_unexpected_byte");
        else begin e = exp_b.pop_front(); check("b_byte", byte_data_b, e); end
      end
      if (frame_dropped_b) drop_b++;
    end
  end

  task automatic strobe_a(input bit en, input logic [95:0] c, input bit expect_accept);
    enable_a = en; counts_a = c; frame_strobe_a = 1'b1;
    if (expect_accept) push_frame(0, en, c, 8, 3, 3);
    step();
    frame_strobe_a = 1'b0; enable_a = 1'($urandom); counts_a = rand96();
  endtask

  task automatic wait_idle(input int which, input int period, input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (which == 0) begin
        byte_ready_a = ((i % period) == 0); counts_a = rand96(); enable_a = 1'($urandom);
      end else begin
        counts_b = 36'(rand96()); enable_b = 1'($urandom);
      end
      @(negedge clk);
      if (which == 0) done = (exp_a.size() == 0) && !busy_a;
      else            done = (exp_b.size() == 0) && !busy_b;
      step();
    end
    if (!done) fail_now({name, "_timeout"});
    check({name, "_queue_empty"}, (which == 0) ? exp_a.size() : exp_b.size(), 0);
    byte_ready_a = 1'b1;
  endtask

  task automatic run_timed(input bit en, input logic [95:0] c, input string tag);
    strobe_a(en, c, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check({tag, "_valid"}, byte_valid_a, 1);
      check({tag, "_busy"}, busy_a, 1);
      step();
    end
    @(negedge clk);
    check({tag, "_busy_end"}, busy_a, 0);
    check({tag, "_valid_end"}, byte_valid_a, 0);
    check({tag, "_queue_empty"}, exp_a.size(), 0);
    step();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [95:0] pat;
    int d0, x0;
    reset = 1'b1;
    enable_a = 0; frame_strobe_a = 0; byte_ready_a = 1; counts_a = '0;
    enable_b = 0; frame_strobe_b = 0; byte_ready_b = 1; counts_b = '0;
    repeat (2) step();
    @(negedge clk);
    check("rst_a_valid", byte_valid_a, 0);
    check("rst_a_data", byte_data_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_drop", frame_dropped_a, 0);
    check("rst_b_valid", byte_valid_b, 0);
    check("rst_b_busy", busy_b, 0);
    step();
    reset = 1'b0;
    step();

    for (int k = 0; k < 12; k++) pat[8 * k +: 8] = 8'(k + 1);
    run_timed(1'b1, pat, "t1");
    run_timed(1'b0, pat, "t2");

    // Sparse ready with the input vector churning after the strobe.
    strobe_a(1'b1, pat, 1);
    wait_idle(0, 3, 300, "t3");

    // Strobe mid-frame is rejected.
    strobe_a(1'b1, rand96(), 1);
    d0 = drop_a;
    repeat (5) step();
    counts_a = rand96(); enable_a = 1'b0; frame_strobe_a = 1'b1;
    step();
    frame_strobe_a = 1'b0;
    @(negedge clk);
    check("t4a_drop_pulse", frame_dropped_a, 1);
    step();
    @(negedge clk);
    check("t4a_drop_clear", frame_dropped_a, 0);
    step();
    wait_idle(0, 1, 100, "t4a");
    check("t4a_drop_count", drop_a - d0, 1);

    // Strobe on the final transfer chains frames back-to-back.
    strobe_a(1'b1, rand96(), 1);
    repeat (15) step();
    d0 = drop_a;
    strobe_a(1'b1, rand96(), 1);
    @(negedge clk);
    check("t4b_valid", byte_valid_a, 1);
    check("t4b_data", byte_data_a, 8'h00);
    check("t4b_busy", busy_a, 1);
    step();
    wait_idle(0, 1, 100, "t4b");
    check("t4b_no_drop", drop_a - d0, 0);

    // Reset mid-frame aborts, then a fresh frame runs complete.
    strobe_a(1'b1, rand96(), 1);
    repeat (7) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("t5_valid", byte_valid_a, 0);
    check("t5_busy", busy_a, 0);
    exp_a.delete();
    reset = 1'b0;
    step();
    x0 = xfer_a;
    strobe_a(1'b1, rand96(), 1);
    wait_idle(0, 1, 100, "t5");
    check("t5_xfer_count", xfer_a - x0, 16);

    for (int r = 0; r < 4; r++) begin
      strobe_a(1'($urandom), rand96(), 1);
      wait_idle(0, 1 + int'($urandom_range(0, 2)), 300, "rand_a");
    end

    // Twelve-bit counters with a partial top byte.
    enable_b = 1'b1; counts_b = 36'hABC_DEF_123; frame_strobe_b = 1'b1;
    foreach (pat[i]) ;
    exp_b.push_back(8'h00); exp_b.push_back(8'h01); exp_b.push_back(8'h02);
    exp_b.push_back(8'h0C); exp_b.push_back(8'h23); exp_b.push_back(8'hF1);
    exp_b.push_back(8'hDE); exp_b.push_back(8'hBC); exp_b.push_back(8'h0A);
    step();
    frame_strobe_b = 1'b0;
    x0 = xfer_b;
    wait_idle(1, 1, 100, "t6");
    check("t6_xfer_count", xfer_b - x0, 9);

    for (int r = 0; r < 3; r++) begin
      logic [35:0] cb;
      bit en;
      cb = 36'(rand96()); en = 1'($urandom);
      enable_b = en; counts_b = cb; frame_strobe_b = 1'b1;
      push_frame(1, en, {60'b0, cb}, 12, 1, 2);
      step();
      frame_strobe_b = 1'b0;
      wait_idle(1, 1, 100, "rand_b");
    end
    check("b_no_drop", drop_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
